datamemory_bus: RTL
===================

Name: datamemory_bus

Overview:
- Next-generation RV32 data memory. Replaces the combinational-read, word-only store path with a clocked, handshaked memory.
- Supports full RV32I load/store widths: LB/LH/LW/LBU/LHU and SB/SH/SW, using per-byte write lanes and sign/zero extension.
- Detects misaligned and illegal accesses; an optional FSM splits misaligned accesses into two word cycles.
- Sits between the ALU/MEM pipeline stage and the register-file writeback mux.

Parameters:
- DM_ADDRESS, 9, byte-address width; storage is 2**(DM_ADDRESS-2) 32-bit words.
- DATA_W, 32, data width; only 32 is supported, and elaboration fails on any other value.
- INIT_ZERO, 0, when 1, storage is cleared to zero at time 0 in simulation only (initial block); never cleared by reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request, from the control unit.
- MemWrite  in  1  store request, from the control unit.
- a  in  DM_ADDRESS  byte address, the LSBs of the ALU result.
- wd  in  DATA_W  store data; the LSB-aligned byte or half is used for SB/SH.
- Funct3  in  3  instruction bits 14:12; selects width and signedness.
- req_ready  out  1  request accepted this cycle when high.
- rd_valid  out  1  one-cycle pulse; rd is valid.
- rd  out  DATA_W  extended load data.
- access_err  out  1  one-cycle pulse; last request was rejected.

Behaviour:
- Reset (asynchronous, rst_n=0): rd=0, rd_valid=0, access_err=0, req_ready=1, FSM=IDLE. Storage contents are not reset.
- Acceptance: a request is accepted on a rising edge when (MemRead|MemWrite) && req_ready. If both strobes are high, MemRead wins and the store is dropped.
- Index: word index = a[DM_ADDRESS-1:2]; byte offset = a[1:0].
- Load Funct3 encodings: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Any other value is illegal.
- Store Funct3 encodings: 000 SB, 001 SH, 010 SW. Any other value is illegal.
- Load extension: the selected byte/half is taken at the offset. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- Store write lanes: SB writes lane a[1:0] with wd[7:0]. SH writes lanes {a[1]*2+1, a[1]*2} with wd[15:0]. SW writes all four lanes.
- Aligned load accepted at edge T: rd and rd_valid=1 are registered at T+1; rd_valid falls at T+2 unless another load is accepted at T+1.
- Back-to-back: req_ready stays 1, so one load completes per cycle.
- Aligned store accepted at edge T: the array is updated at T. A load accepted at T+1 to the same word returns the new data (read-after-write, no hazard). A store never raises rd_valid.
- rd holds its last value when rd_valid=0.
- Misaligned access: LH/LHU/SH with a[0]=1, or LW/SW with a[1:0]!=0. Handling depends on the optional feature.
- Illegal Funct3: no array write. access_err=1 and rd_valid=0 at T+1; rd unchanged.
- FSM: IDLE; SPLIT (feature builds only). No other states.

Optional Feature:
- Macro: DM_MISALIGN_SPLIT_EN.
- Without the macro, a misaligned access is rejected. access_err=1 at T+1, no array write, rd_valid=0, rd unchanged. The FSM never leaves IDLE.
- With the macro, a misaligned access is accepted at T and the FSM goes IDLE->SPLIT:
  - At T: the low part is accessed at word index w (lanes a[1:0]..3). req_ready=0 during T+1.
  - At T+1: the high part is accessed at word w+1, wrapping to 0 from the top index. FSM returns SPLIT->IDLE.
  - Loads: the assembled, extended rd is output with rd_valid=1 at T+2.
  - Stores: the low lanes are written at T and the high lanes at T+1.
  - Reset during SPLIT aborts the access: the first-half write persists, the second half is not written, and no rd_valid is issued.
  - access_err is raised only for illegal Funct3.

Test Plan:
- SW a=0x010 wd=0xDEADBEEF, then LW a=0x010 -> rd=0xDEADBEEF, rd_valid pulse exactly one cycle after the load is accepted.
- SB a=0x021 wd=0x000000F0 over word 0x00000000, then LB a=0x021 -> 0xFFFFFFF0; LBU a=0x021 -> 0x000000F0; LW a=0x020 -> 0x0000F000.
- SH a=0x032 wd=0x00008001, then LH a=0x032 -> 0xFFFF8001; LHU a=0x032 -> 0x00008001; back-to-back loads give two consecutive rd_valid cycles.
- LW a=0x041 (macro off) -> access_err=1, rd_valid=0, rd unchanged; Funct3=011 load -> access_err=1; memory untouched in both cases.
- (Macro on) SW a=0x1FE wd=0x11223344 -> word 0x7F lanes 2,3 = 0x44,0x33; word 0 lanes 0,1 = 0x22,0x11 (wrap). Then LW a=0x1FE -> req_ready=0 for one cycle, rd=0x11223344 at T+2.
- Assert rst_n low mid-SPLIT of a misaligned SW -> outputs are reset values immediately; only the first-half lanes are written; req_ready=1 after release.

Source files
------------

// File: rtl/datamemory_bus.sv
// RV32 data memory with a clocked, handshaked port and byte/half/word loads and stores.
// Build option: define DM_MISALIGN_SPLIT_EN to split misaligned accesses into two word cycles.
module datamemory_bus #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int INIT_ZERO  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic                  req_ready,
   output logic                  rd_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  access_err
);

   localparam int IW    = DM_ADDRESS - 2;
   localparam int DEPTH = 1 << IW;

`ifdef DM_MISALIGN_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   typedef enum logic {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;

   generate
      if (DATA_W != 32) begin : g_bad_width
         $error("datamemory_bus supports DATA_W == 32 only");
      end
   endgenerate

   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         2'b10:   size_mask = 4'b1111;
         default: size_mask = 4'b0000;
      endcase
   endfunction

   function automatic logic f3_legal(input logic is_load, input logic [2:0] f3);
      case (f3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = is_load;
         default:                f3_legal = 1'b0;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
      case (f3[1:0])
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off != 2'b00);
         default: misaligned = 1'b0;
      endcase
   endfunction

   // The word pair is {high word, low word}; the access starts at byte 'off' of the low word.
   function automatic logic [31:0] extend(input logic [63:0] pair, input logic [1:0] off,
                                          input logic [2:0] f3);
      logic [63:0] sh;
      sh = pair >> {off, 3'b000};
      case (f3)
         3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
         3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
         3'b100:  extend = {24'h000000, sh[7:0]};
         3'b101:  extend = {16'h0000, sh[15:0]};
         default: extend = sh[31:0];
      endcase
   endfunction

   logic [31:0]   r_mem [0:DEPTH-1];
   state_t        r_state;
   logic [IW-1:0] r_idx;
   logic [1:0]    r_off;
   logic [2:0]    r_f3;
   logic          r_is_load;
   logic [3:0]    r_hi_mask;
   logic [31:0]   r_hi_data;
   logic [31:0]   r_word_lo;
   logic [31:0]   r_word_hi;
   logic          r_pend;
   logic          r_err_pend;

   logic [IW-1:0] w_idx;
   logic [IW-1:0] w_idx_next;
   logic [IW-1:0] w_rd_idx;
   logic [1:0]    w_off;
   logic          w_accept;
   logic          w_err;
   logic          w_go;
   logic          w_split;
   logic [7:0]    w_mask8;
   logic [63:0]   w_data64;
   logic [31:0]   w_rd_word;
   logic [3:0]    w_we_mask;
   logic [IW-1:0] w_we_idx;
   logic [31:0]   w_we_data;

   assign w_idx      = a[DM_ADDRESS-1:2];
   assign w_off      = a[1:0];
   assign w_idx_next = r_idx + {{(IW-1){1'b0}}, 1'b1};
   assign w_rd_idx   = (r_state == ST_SPLIT) ? w_idx_next : w_idx;
   assign w_rd_word  = r_mem[w_rd_idx];
   assign w_accept   = (MemRead | MemWrite) & req_ready;
   assign w_err      = w_accept & (~f3_legal(MemRead, Funct3) |
                                   (misaligned(Funct3, w_off) & ~SPLIT_EN));
   assign w_go       = w_accept & ~w_err;
   assign w_split    = w_go & misaligned(Funct3, w_off);
   assign w_mask8    = {4'b0000, size_mask(Funct3)} << w_off;
   assign w_data64   = {32'h00000000, wd} << {w_off, 3'b000};

   // Write-port select: second half of a split store, else an accepted store (MemRead wins).
   always_comb begin
      w_we_mask = 4'b0000;
      w_we_idx  = w_idx;
      w_we_data = w_data64[31:0];
      if (!rst_n) begin
         w_we_mask = 4'b0000;
      end else if (r_state == ST_SPLIT) begin
         w_we_idx  = w_idx_next;
         w_we_data = r_hi_data;
         if (!r_is_load) w_we_mask = r_hi_mask;
         else            w_we_mask = 4'b0000;
      end else if (w_go && !MemRead) begin
         w_we_mask = w_mask8[3:0];
      end else begin
         w_we_mask = 4'b0000;
      end
   end

   generate
      if (INIT_ZERO != 0) begin : g_init_zero
         initial begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= 32'h00000000;
         end
      end
   endgenerate

   // Storage array with per-byte lane enables; contents survive reset.
   always_ff @(posedge clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_we_mask[k]) r_mem[w_we_idx][8*k +: 8] <= w_we_data[8*k +: 8];
      end
   end

   // Request capture, split sequencing and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         req_ready  <= 1'b1;
         rd_valid   <= 1'b0;
         access_err <= 1'b0;
         rd         <= '0;
         r_pend     <= 1'b0;
         r_err_pend <= 1'b0;
         r_idx      <= '0;
         r_off      <= 2'b00;
         r_f3       <= 3'b000;
         r_is_load  <= 1'b0;
         r_hi_mask  <= 4'b0000;
         r_hi_data  <= 32'h00000000;
         r_word_lo  <= 32'h00000000;
         r_word_hi  <= 32'h00000000;
      end else begin
         rd_valid   <= r_pend;
         access_err <= r_err_pend;
         if (r_pend) rd <= extend({r_word_hi, r_word_lo}, r_off, r_f3);
         r_pend     <= 1'b0;
         r_err_pend <= w_err;
         case (r_state)
            ST_IDLE: begin
               if (w_go) begin
                  r_idx     <= w_idx;
                  r_off     <= w_off;
                  r_f3      <= Funct3;
                  r_is_load <= MemRead;
                  r_hi_mask <= w_mask8[7:4];
                  r_hi_data <= w_data64[63:32];
                  if (MemRead) r_word_lo <= w_rd_word;
                  if (w_split) begin
                     r_state   <= ST_SPLIT;
                     req_ready <= 1'b0;
                  end else begin
                     r_pend <= MemRead;
                  end
               end
            end
            ST_SPLIT: begin
               if (r_is_load) r_word_hi <= w_rd_word;
               r_pend    <= r_is_load;
               r_state   <= ST_IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               r_state   <= ST_IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
